// File: rtl/check_password_pkg.sv
// Shared types and default constants for the password-entry gate.
package check_password_pkg;

  localparam int unsigned PSWD_LEN_DEF = 4;
  localparam int unsigned DIGIT_W_DEF  = 4;

  // First-entered digit sits in the most significant nibble (index 0 = 4).
  localparam logic [PSWD_LEN_DEF*DIGIT_W_DEF-1:0] PSWD_ROM_DEF = {4'd4, 4'd6, 4'd9, 4'd6};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    CHECK = 2'd2,
    AUTH  = 2'd3
  } state_t;

endpackage

// File: rtl/password_rom.sv
// Combinational lookup of one stored password digit by entry index.
module password_rom
  import check_password_pkg::*;
#(
  parameter int unsigned PSWD_LEN = PSWD_LEN_DEF,
  parameter int unsigned DIGIT_W  = DIGIT_W_DEF,
  parameter int unsigned IDX_W    = 2,
  parameter logic [PSWD_LEN*DIGIT_W-1:0] PSWD_ROM = PSWD_ROM_DEF
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [DIGIT_W-1:0] digit_c
);

  // Select the digit for idx; index 0 is the most significant slice.
  always_comb begin
    digit_c = '0;
    for (int unsigned i = 0; i < PSWD_LEN; i++) begin
      if (idx == IDX_W'(i)) begin
        digit_c = PSWD_ROM[(PSWD_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

endmodule

// File: rtl/check_password.sv
// Password-entry gate: collects PSWD_LEN confirmed digits, compares them
// against the stored password and holds the authenticated state until logout.
module check_password
  import check_password_pkg::*;
#(
  parameter int unsigned PSWD_LEN = PSWD_LEN_DEF,
  parameter int unsigned DIGIT_W  = DIGIT_W_DEF,
  parameter logic [PSWD_LEN*DIGIT_W-1:0] PSWD_ROM = PSWD_ROM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Load_Button_PSWD_Game_Control,
  input  logic               Logout_Pulse,
  input  logic [DIGIT_W-1:0] Data_in,
  output logic               Authenticated,
  output logic               Login_Green,
  output logic               Logout_RED
);

  localparam int unsigned IDX_W = (PSWD_LEN > 1) ? $clog2(PSWD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PSWD_LEN - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               mismatch;
  logic               btn_q;
  logic [DIGIT_W-1:0] rom_digit_c;
  logic               press_c;
  logic               digit_ne_c;

  password_rom #(
    .PSWD_LEN (PSWD_LEN),
    .DIGIT_W  (DIGIT_W),
    .IDX_W    (IDX_W),
    .PSWD_ROM (PSWD_ROM)
  ) u_rom (
    .idx     (idx),
    .digit_c (rom_digit_c)
  );

  // Rising edge of the confirm button; a held button yields one press.
  assign press_c    = Load_Button_PSWD_Game_Control & ~btn_q;
  assign digit_ne_c = (Data_in != rom_digit_c);

  // LEDs decode straight from the registered authenticated flag.
  assign Login_Green = Authenticated;
  assign Logout_RED  = ~Authenticated;

  // Entry FSM, button history and registered authenticated flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      mismatch      <= 1'b0;
      btn_q         <= 1'b0;
      Authenticated <= 1'b0;
    end else begin
      btn_q         <= Load_Button_PSWD_Game_Control;
      Authenticated <= (state == AUTH);
      if (Logout_Pulse) begin
        state    <= IDLE;
        idx      <= '0;
        mismatch <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press_c) begin
              mismatch <= digit_ne_c;
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= CHECK;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ENTRY;
              end
            end
          end
          ENTRY: begin
            if (press_c) begin
              mismatch <= mismatch | digit_ne_c;
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= CHECK;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          CHECK: begin
            idx      <= '0;
            mismatch <= 1'b0;
            state    <= mismatch ? IDLE : AUTH;
          end
          AUTH: begin
            idx      <= '0;
            mismatch <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            idx      <= '0;
            mismatch <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_check_password.sv
// Directed self-checking bench for the password-entry gate.
module tb_check_password;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       logout;
  logic [3:0] data;
  logic       auth;
  logic       green;
  logic       red;

  int unsigned n_total;
  int unsigned n_pass;

  check_password dut (
    .clk                           (clk),
    .rst                           (rst),
    .Load_Button_PSWD_Game_Control (btn),
    .Logout_Pulse                  (logout),
    .Data_in                       (data),
    .Authenticated                 (auth),
    .Login_Green                   (green),
    .Logout_RED                    (red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Compare all three outputs against the expected login status.
  task automatic check_login(input string tag, input logic exp);
    check({tag, ".auth"},  auth,  exp);
    check({tag, ".green"}, green, exp);
    check({tag, ".red"},   red,   ~exp);
  endtask

  // One clean press; returns half a cycle after the edge that detects it.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    data = d;
    btn  = 1'b1;
    @(negedge clk);
    btn  = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic do_logout();
    @(negedge clk);
    logout = 1'b1;
    @(negedge clk);
    logout = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b0;
    btn     = 1'b0;
    logout  = 1'b0;
    data    = 4'd0;

    // Reset values
    #12;
    check_login("reset", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    check_login("post_reset", 1'b0);

    // Correct password with exact latency: CHECK after edge E, AUTH at E+1, output at E+2
    enter4(4'd4, 4'd6, 4'd9, 4'd6);
    check("lat_e0", auth, 1'b0);
    @(negedge clk);
    check("lat_e1", auth, 1'b0);
    @(negedge clk);
    check_login("login", 1'b1);

    // Presses while authenticated are ignored
    press(4'd4);
    check("auth_hold0", auth, 1'b1);
    press(4'd5);
    press(4'd6);
    press(4'd7);
    wait_cycles(3);
    check_login("auth_ignore", 1'b1);

    // Logout: output still high at the sampling edge, low one edge later
    do_logout();
    check("logout_e0", auth, 1'b1);
    @(negedge clk);
    check_login("logout", 1'b0);

    // Wrong password stays logged out
    enter4(4'd4, 4'd5, 4'd6, 4'd7);
    wait_cycles(3);
    check_login("wrong_4567", 1'b0);

    // Wrong third digit, then immediate retry
    enter4(4'd4, 4'd6, 4'd1, 4'd6);
    wait_cycles(3);
    check_login("wrong_4616", 1'b0);
    enter4(4'd4, 4'd6, 4'd9, 4'd6);
    wait_cycles(2);
    check_login("retry", 1'b1);
    do_logout();
    wait_cycles(1);
    check("retry_logout", auth, 1'b0);

    // Button held 20 cycles counts as one press
    @(negedge clk);
    data = 4'd4;
    btn  = 1'b1;
    wait_cycles(20);
    btn  = 1'b0;
    press(4'd6);
    press(4'd9);
    press(4'd6);
    wait_cycles(2);
    check_login("held_btn", 1'b1);
    do_logout();
    wait_cycles(1);
    check("held_logout", auth, 1'b0);

    // Logout mid-entry abandons the partial sequence
    press(4'd4);
    press(4'd6);
    do_logout();
    press(4'd9);
    press(4'd6);
    wait_cycles(3);
    check_login("mid_logout", 1'b0);
    do_logout();

    // Logout wins over a simultaneous final press
    press(4'd4);
    press(4'd6);
    press(4'd9);
    @(negedge clk);
    data   = 4'd6;
    btn    = 1'b1;
    logout = 1'b1;
    @(negedge clk);
    btn    = 1'b0;
    logout = 1'b0;
    wait_cycles(3);
    check_login("logout_prio", 1'b0);
    enter4(4'd4, 4'd6, 4'd9, 4'd6);
    wait_cycles(2);
    check_login("after_prio", 1'b1);

    // Asynchronous reset while authenticated
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_login("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    check_login("after_rst", 1'b0);
    enter4(4'd4, 4'd6, 4'd9, 4'd6);
    wait_cycles(2);
    check("rst_relogin", auth, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/check_password.md
Name: check_password

Overview:
- Password-entry gate for the game controller: the user keys 4-bit digits on Data_in and confirms each with Load_Button_PSWD_Game_Control.
- After PSWD_LEN confirmed digits, the sequence is compared against a password held in an internal ROM.
- On a full match the block enters the authenticated state and drives the login LEDs.
- It stays authenticated until Logout_Pulse or reset; it gates access for the downstream game logic.

Parameters:
- PSWD_LEN, 4: number of digits in the password.
- DIGIT_W, 4: width of one digit (Data_in width).
- PSWD_ROM, {4'd4,4'd6,4'd9,4'd6}: stored password; first-entered digit first, index 0 = 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Load_Button_PSWD_Game_Control  in  1  digit-confirm button, level input; only a rising edge is acted on.
- Logout_Pulse  in  1  logout request, sampled each clock.
- Data_in  in  DIGIT_W  current digit; sampled on the clock that detects the button edge.
- Authenticated  out  1  high while logged in.
- Login_Green  out  1  green LED; equal to Authenticated.
- Logout_RED  out  1  red LED; equal to NOT Authenticated.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; digit index=0; mismatch flag=0; button history=0.
  - Authenticated=0, Login_Green=0, Logout_RED=1.
  - All outputs are registered or decoded from the registered state; no glitch paths.
- Button edge detect:
  - btn_q is a registered copy of the button.
  - press = button & ~btn_q.
  - A button held for many cycles counts as exactly one press.
  - A re-press requires at least one low sample in between.
- States: IDLE, ENTRY, CHECK, AUTH.
- IDLE: on press, compare Data_in with PSWD_ROM[0], set mismatch accordingly, index=1, go to ENTRY.
- ENTRY: on press, mismatch |= (Data_in != PSWD_ROM[index]) and index++.
  - When this press is digit number PSWD_LEN, go to CHECK.
  - A wrong digit does not abort early; all PSWD_LEN digits are always consumed.
- CHECK (one cycle):
  - mismatch=0: go to AUTH.
  - Otherwise go to IDLE with index=0 and mismatch=0.
  - Presses during CHECK are ignored.
- AUTH:
  - Authenticated=1; stays there indefinitely.
  - All presses are ignored; digits entered while logged in have no effect.
  - Logout_Pulse=1 on a clock edge: go to IDLE, clear index and mismatch.
- Logout_Pulse in IDLE/ENTRY/CHECK: abandon any partial entry and go to IDLE with index=0.
  - Logout has priority over a simultaneous press; that press is dropped.
- Latency: the clock edge that detects the final press moves to CHECK. Authenticated rises on the second edge after that one.
- Logout latency: Authenticated falls on the edge after the edge that samples Logout_Pulse=1.
- Failed attempts:
  - No lockout and no error output; Logout_RED simply stays high.
  - The user may retry immediately from IDLE.
- Index wrap: the index never exceeds PSWD_LEN-1; it is cleared on every exit to IDLE.
- Reset asserted mid-entry or mid-AUTH returns immediately to the reset values above.

Decomposition:
- Shared package check_password_pkg holds:
  - state enum {IDLE, ENTRY, CHECK, AUTH};
  - PSWD_LEN and DIGIT_W defaults;
  - the default password constant.
- Sub-module password_rom: combinational lookup, index in, DIGIT_W digit out, contents from PSWD_ROM.
- Edge detect and FSM stay in check_password.

Test Plan:
- Reset with rst=0 -> Authenticated=0, Login_Green=0, Logout_RED=1. Release rst=1 -> outputs unchanged, state IDLE.
- Enter 4,6,9,6 (one clean press each, Data_in stable before the press) -> Authenticated=1 and Login_Green=1 two clocks after the 4th press edge; Logout_RED=0.
- While authenticated, enter 4,5,6,7 -> Authenticated stays 1 throughout (presses ignored).
- Logout_Pulse=1 for one clock -> Authenticated=0, Logout_RED=1 next edge. Then enter 4,5,6,7 -> remains logged out after CHECK.
- Enter 4,6,1,6 -> no authentication. Then 4,6,9,6 -> authenticated (retry works).
- Edge cases:
  - Hold the button high 20 cycles on digit 4, then complete 6,9,6 -> authenticates (the hold counts once).
  - Enter 4,6, then Logout_Pulse, then 9,6 -> not authenticated.
  - Drop rst while in AUTH -> Authenticated=0 immediately (asynchronous).
